// File: rtl/tpm_cmd_parser_if.sv
// tpm_cmd_parser_if: connects the receive-buffer byte stream and the parsed-command outputs.
// Stream side: byte_in/byte_valid/byte_last/locality_in carry a frame in, and byte_ready accepts it.
// Command side: cmd_valid/cmd_start_n/tpm_cc/cmd_param/locality/auth_handle/parse_rc go out, and cmd_ack returns.
// Modport slave is the parser. Modport master is the host buffer together with the command consumer.
interface tpm_cmd_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic [7:0]  locality_in;
  logic        cmd_ack;
  logic        cmd_valid;
  logic        cmd_start_n;
  logic [31:0] tpm_cc;
  logic [33:0] cmd_param;
  logic [7:0]  locality;
  logic [31:0] auth_handle;
  logic [31:0] parse_rc;

  modport slave (
    input  byte_in, byte_valid, byte_last, locality_in, cmd_ack,
    output byte_ready, cmd_valid, cmd_start_n, tpm_cc, cmd_param, locality, auth_handle, parse_rc
  );

  modport master (
    output byte_in, byte_valid, byte_last, locality_in, cmd_ack,
    input  byte_ready, cmd_valid, cmd_start_n, tpm_cc, cmd_param, locality, auth_handle, parse_rc
  );
endinterface

// File: rtl/tpm_cmd_parser.sv
// tpm_cmd_parser: parses a big-endian TPM command byte stream into the code, parameters and header response code.
// Latency: cmd_valid rises one cycle after the final byte (byte_last) is accepted; cmd_start_n pulses low on that cycle.
// Backpressure: byte_ready is low while a parsed command is held (EMIT) and stays low until cmd_ack.
// Ports: clock, reset_n (async, active-low), bus (tpm_cmd_parser_if.slave).
module tpm_cmd_parser #(
  parameter int MAX_CMD_SIZE = 4096,
  parameter int SIZE_W       = 13
) (
  input logic             clock,
  input logic             reset_n,
  tpm_cmd_parser_if.slave bus
);
  localparam logic [31:0] RC_SUCCESS      = 32'h0000_0000;
  localparam logic [31:0] RC_BAD_TAG      = 32'h0000_001E;
  localparam logic [31:0] RC_COMMAND_SIZE = 32'h0000_0142;
  localparam logic [31:0] CC_HIER_CTRL    = 32'h0000_0121;
  localparam logic [31:0] CC_SELF_TEST    = 32'h0000_0143;
  localparam logic [31:0] CC_STARTUP      = 32'h0000_0144;
  localparam logic [31:0] CC_SHUTDOWN     = 32'h0000_0145;

  typedef enum logic [3:0] {
    IDLE, TAG, SIZE, CC, HANDLE, AUTHSZ, AUTHSKIP, PARAM, DRAIN, EMIT
  } state_t;

  state_t            state, parseNext, stateAfter;
  logic [SIZE_W-1:0] cnt, cntNext, cmdSize;
  logic [31:0]       shiftReg, shiftNext, authLeft;
  logic [15:0]       tag;
  logic [1:0]        fieldCnt;
  logic [2:0]        paramCnt, paramsAfter, paramNeed;
  logic [31:0]       ccReg, ccEff, authHandle, rcReg, fieldRc, rcAfter;
  logic [33:0]       cmdParam;
  logic [7:0]        localityReg;
  logic              byteReady, cmdValid, cmdStartN;
  logic              accept, fieldDone, sizeKnown, atSize, complete;

  // Number of parameter bytes a command must carry before the frame may end.
  function automatic logic [2:0] needOf(input logic [31:0] cc);
    case (cc)
      CC_STARTUP, CC_SHUTDOWN: return 3'd2;
      CC_SELF_TEST:            return 3'd1;
      CC_HIER_CTRL:            return 3'd5;
      default:                 return 3'd0;
    endcase
  endfunction

  always_comb begin
    accept    = bus.byte_valid && byteReady;
    shiftNext = {shiftReg[23:0], bus.byte_in};
    cntNext   = (state == IDLE) ? {{(SIZE_W-1){1'b0}}, 1'b1} : cnt + 1'b1;
    fieldDone = (fieldCnt == 2'd3);
    parseNext = state;
    fieldRc   = RC_SUCCESS;
    sizeKnown = 1'b0;
    ccEff     = ccReg;
    case (state)
      IDLE: parseNext = TAG;
      TAG: begin
        if (shiftNext[15:0] == 16'h8001 || shiftNext[15:0] == 16'h8002) begin
          parseNext = SIZE;
        end else begin
          fieldRc   = RC_BAD_TAG;
          parseNext = DRAIN;
        end
      end
      SIZE: begin
        if (fieldDone) begin
          if (shiftNext < 32'd10 || shiftNext > 32'(MAX_CMD_SIZE)) begin
            fieldRc   = RC_COMMAND_SIZE;
            parseNext = DRAIN;
          end else begin
            parseNext = CC;
          end
        end
      end
      CC: begin
        sizeKnown = 1'b1;
        ccEff     = shiftNext;
        if (fieldDone) begin
          parseNext = (shiftNext == CC_HIER_CTRL) ? HANDLE :
                      (tag == 16'h8002)           ? AUTHSZ : PARAM;
        end
      end
      HANDLE: begin
        sizeKnown = 1'b1;
        if (fieldDone) parseNext = (tag == 16'h8002) ? AUTHSZ : PARAM;
      end
      AUTHSZ: begin
        sizeKnown = 1'b1;
        if (fieldDone) parseNext = (shiftNext == 32'd0) ? PARAM : AUTHSKIP;
      end
      AUTHSKIP: begin
        sizeKnown = 1'b1;
        if (authLeft == 32'd1) parseNext = PARAM;
      end
      PARAM:   sizeKnown = 1'b1;
      default: ;
    endcase

    // Parameter bytes seen once this byte lands; saturates so long frames cannot wrap.
    paramsAfter = (state != PARAM) ? 3'd0 : (paramCnt == 3'd7) ? 3'd7 : paramCnt + 3'd1;
    paramNeed   = needOf(ccEff);
    atSize      = sizeKnown && (cntNext == cmdSize);
    complete    = (parseNext == PARAM) && (paramsAfter >= paramNeed);

    // Outside DRAIN no error has been recorded yet, so the first one found here wins.
    rcAfter    = rcReg;
    stateAfter = parseNext;
    if (state != DRAIN) begin
      rcAfter = RC_SUCCESS;
      if (fieldRc != RC_SUCCESS) begin
        rcAfter = fieldRc;
      end else if (bus.byte_last ? !(atSize && complete) : atSize) begin
        rcAfter    = RC_COMMAND_SIZE;
        stateAfter = DRAIN;
      end
    end
    if (bus.byte_last) stateAfter = EMIT;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cmdSize     <= '0;
      shiftReg    <= '0;
      authLeft    <= '0;
      tag         <= '0;
      fieldCnt    <= '0;
      paramCnt    <= '0;
      ccReg       <= '0;
      authHandle  <= '0;
      rcReg       <= '0;
      cmdParam    <= '0;
      localityReg <= '0;
      byteReady   <= 1'b0;
      cmdValid    <= 1'b0;
      cmdStartN   <= 1'b1;
    end else begin
      cmdStartN <= 1'b1;
      if (state == EMIT) begin
        if (bus.cmd_ack) begin
          state     <= IDLE;
          cmdValid  <= 1'b0;
          byteReady <= 1'b1;
        end
      end else begin
        byteReady <= 1'b1;
        if (accept) begin
          cnt      <= cntNext;
          shiftReg <= shiftNext;
          state    <= stateAfter;
          rcReg    <= rcAfter;
          case (state)
            IDLE: begin
              ccReg       <= '0;
              cmdParam    <= '0;
              authHandle  <= '0;
              fieldCnt    <= '0;
              paramCnt    <= '0;
              localityReg <= bus.locality_in;
            end
            TAG: tag <= shiftNext[15:0];
            SIZE: begin
              fieldCnt <= fieldCnt + 2'd1;
              if (fieldDone) cmdSize <= shiftNext[SIZE_W-1:0];
            end
            CC: begin
              fieldCnt <= fieldCnt + 2'd1;
              if (fieldDone) ccReg <= shiftNext;
            end
            HANDLE: begin
              fieldCnt <= fieldCnt + 2'd1;
              if (fieldDone) authHandle <= shiftNext;
            end
            AUTHSZ: begin
              fieldCnt <= fieldCnt + 2'd1;
              if (fieldDone) authLeft <= shiftNext;
            end
            AUTHSKIP: authLeft <= authLeft - 32'd1;
            PARAM: begin
              paramCnt <= paramsAfter;
              case (ccReg)
                CC_STARTUP, CC_SHUTDOWN: begin
                  if (paramCnt == 3'd0)      cmdParam[15:8] <= bus.byte_in;
                  else if (paramCnt == 3'd1) cmdParam[7:0]  <= bus.byte_in;
                end
                CC_SELF_TEST: if (paramCnt == 3'd0) cmdParam[0] <= |bus.byte_in;
                CC_HIER_CTRL: begin
                  // 4-byte enable shifts in MSB first above the state bit.
                  if (paramCnt < 3'd4)       cmdParam[32:1] <= {cmdParam[24:1], bus.byte_in};
                  else if (paramCnt == 3'd4) cmdParam[0]    <= |bus.byte_in;
                end
                default: ;
              endcase
            end
            default: ;
          endcase
          if (bus.byte_last) begin
            cmdValid  <= 1'b1;
            cmdStartN <= 1'b0;
            byteReady <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.byte_ready  = byteReady;
  assign bus.cmd_valid   = cmdValid;
  assign bus.cmd_start_n = cmdStartN;
  assign bus.tpm_cc      = ccReg;
  assign bus.cmd_param   = cmdParam;
  assign bus.locality    = localityReg;
  assign bus.auth_handle = authHandle;
  assign bus.parse_rc    = rcReg;
endmodule

// File: tb/tb_tpm_cmd_parser.sv
// tb_tpm_cmd_parser: drives table-driven command frames into tpm_cmd_parser and scoreboards the parsed results.
// Latency: each frame's latency and start-pulse width are checked, as are backpressure while held and a mid-frame reset.
// Backpressure: the bench holds cmd_ack low for a while and offers the next frame during that time.
module tb_tpm_cmd_parser;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  tpm_cmd_parser_if bus();

  tpm_cmd_parser #(.MAX_CMD_SIZE(4096), .SIZE_W(13)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [319:0] data;  // frame bytes, right-justified, byte 0 most significant
    int           len;
    logic [7:0]   loc;
    logic [31:0]  cc;
    logic [33:0]  prm;
    logic [31:0]  hdl;
    logic [31:0]  rc;
  } vec_t;

  vec_t vecs[13];
  vec_t sb[$];
  vec_t mon;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [319:0] d, input int len, input logic [7:0] loc,
                              input logic [31:0] cc, input logic [33:0] prm,
                              input logic [31:0] hdl, input logic [31:0] rc);
    vec_t v;
    v.data = d; v.len = len; v.loc = loc; v.cc = cc; v.prm = prm; v.hdl = hdl; v.rc = rc;
    return v;
  endfunction

  function automatic logic [7:0] byteOf(input vec_t v, input int i);
    return v.data[8*(v.len-1-i) +: 8];
  endfunction

  // Scoreboard: compare each newly presented command against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && bus.cmd_valid && !bus.cmd_start_n) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon = sb.pop_front();
        chk("tpm_cc", bus.tpm_cc, mon.cc);
        chk("cmd_param", bus.cmd_param, mon.prm);
        chk("auth_handle", bus.auth_handle, mon.hdl);
        chk("parse_rc", bus.parse_rc, mon.rc);
        chk("locality", bus.locality, mon.loc);
      end
    end
  end

  // Offer the first n bytes of a frame and return #1 after the edge that accepted the last of them.
  task automatic sendBytes(input vec_t v, input int n);
    for (int i = 0; i < n; i++) begin
      int waitCnt;
      bus.byte_in     = byteOf(v, i);
      bus.byte_last   = (i == v.len - 1);
      bus.byte_valid  = 1'b1;
      bus.locality_in = v.loc;
      waitCnt = 0;
      @(negedge clock);
      while (!bus.byte_ready && waitCnt < 100) begin
        waitCnt++;
        @(negedge clock);
      end
      if (waitCnt >= 100) begin
        chk("accept_timeout", 64'(waitCnt), 0);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
    end
  endtask

  task automatic checkEmitEntry();
    chk("latency_valid", bus.cmd_valid, 1);
    chk("start_n_low", bus.cmd_start_n, 0);
    chk("ready_low_emit", bus.byte_ready, 0);
  endtask

  task automatic ackCmd(input bit ackNow);
    if (!ackNow) begin
      @(posedge clock);
      #1;
      chk("start_n_width", bus.cmd_start_n, 1);
      chk("valid_hold", bus.cmd_valid, 1);
    end
    bus.cmd_ack = 1'b1;
    @(posedge clock);
    #1;
    bus.cmd_ack = 1'b0;
    chk("valid_drop", bus.cmd_valid, 0);
  endtask

  task automatic runVec(input vec_t v, input bit ackNow);
    sb.push_back(v);
    sendBytes(v, v.len);
    checkEmitEntry();
    ackCmd(ackNow);
  endtask

  task automatic chkReset();
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_start_n", bus.cmd_start_n, 1);
    chk("rst_tpm_cc", bus.tpm_cc, 0);
    chk("rst_cmd_param", bus.cmd_param, 0);
    chk("rst_auth_handle", bus.auth_handle, 0);
    chk("rst_parse_rc", bus.parse_rc, 0);
    chk("rst_locality", bus.locality, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.byte_last   = 1'b0;
    bus.locality_in = 8'h00;
    bus.cmd_ack     = 1'b0;
    reset_n         = 1'b0;

    vecs[0]  = mk(96'h8001_0000_000C_0000_0144_0000, 12, 8'h01, 32'h144, 34'h0, 32'h0, 32'h0);
    vecs[1]  = mk(256'h8002_0000_0020_0000_0121_4000_000C_0000_0009_1122_3344_5566_7788_9940_0000_0B01,
                  32, 8'h02, 32'h121, 34'h0_8000_0017, 32'h4000_000C, 32'h0);
    vecs[2]  = mk(96'h8003_0000_000C_0000_0144_0000, 12, 8'h04, 32'h0, 34'h0, 32'h0, 32'h1E);
    vecs[3]  = mk(80'h8001_0000_000C_0000_0144, 10, 8'h08, 32'h144, 34'h0, 32'h0, 32'h142);
    vecs[4]  = mk(96'h8001_0000_0006_0000_0144_0000, 12, 8'h01, 32'h0, 34'h0, 32'h0, 32'h142);
    vecs[5]  = mk(96'h8001_0000_000C_0000_0145_0001, 12, 8'h10, 32'h145, 34'h1, 32'h0, 32'h0);
    vecs[6]  = mk(88'h8001_0000_000B_0000_0143_01, 11, 8'h02, 32'h143, 34'h1, 32'h0, 32'h0);
    vecs[7]  = mk(96'h8001_0000_000C_0000_017B_0010, 12, 8'h04, 32'h17B, 34'h0, 32'h0, 32'h0);
    vecs[8]  = mk(112'h8001_0000_000C_0000_0145_0001_AABB, 14, 8'h08, 32'h145, 34'h1, 32'h0, 32'h142);
    vecs[9]  = mk(88'h8001_0000_000B_0000_0144_00, 11, 8'h01, 32'h144, 34'h0, 32'h0, 32'h142);
    vecs[10] = mk(64'h8001_0000_1001_0000, 8, 8'h02, 32'h0, 34'h0, 32'h0, 32'h142);
    vecs[11] = mk(80'h8001_0000_000A_0000_017B, 10, 8'h04, 32'h17B, 34'h0, 32'h0, 32'h0);
    vecs[12] = mk(128'h8002_0000_0010_0000_0145_0000_0000_0001, 16, 8'h08, 32'h145, 34'h1, 32'h0, 32'h0);

    repeat (3) @(posedge clock);
    #1;
    chkReset();
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) runVec(vecs[i], (i % 2) == 0);

    // Hold the Startup result unacknowledged while the Shutdown frame is offered.
    sb.push_back(vecs[0]);
    sendBytes(vecs[0], vecs[0].len);
    checkEmitEntry();
    sb.push_back(vecs[5]);
    bus.byte_in     = byteOf(vecs[5], 0);
    bus.byte_valid  = 1'b1;
    bus.locality_in = vecs[5].loc;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("bp_byte_ready", bus.byte_ready, 0);
      chk("bp_cmd_valid", bus.cmd_valid, 1);
      chk("bp_tpm_cc", bus.tpm_cc, vecs[0].cc);
      chk("bp_locality", bus.locality, vecs[0].loc);
    end
    @(posedge clock);
    #1;
    bus.cmd_ack = 1'b1;
    @(posedge clock);
    #1;
    bus.cmd_ack = 1'b0;
    chk("bp_valid_drop", bus.cmd_valid, 0);
    sendBytes(vecs[5], vecs[5].len);
    checkEmitEntry();
    ackCmd(1'b0);

    // Reset arrives while byte 5 of a frame is offered; that frame must vanish.
    sendBytes(vecs[1], 5);
    bus.byte_in    = byteOf(vecs[1], 5);
    bus.byte_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chkReset();
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    runVec(vecs[0], 1'b0);

    repeat (2) @(posedge clock);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tpm_cmd_parser.md
Name: tpm_cmd_parser

Overview:
- Upstream of the TPM management module.
- Accepts a TPM command as a byte stream from the host-interface receive buffer (LPC/SPI FIFO), one byte per handshake.
- Parses the big-endian command header (tag, commandSize, commandCode), handle area and authorization area.
- Presents tpm_cc, a packed cmd_param, locality and a header-level response code to the management module and execution engine, then holds them until acknowledged.

Parameters:
- MAX_CMD_SIZE, 4096: largest legal commandSize in bytes.
- SIZE_W, 13: width of the byte counter; must hold MAX_CMD_SIZE.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- byte_in  input  8  command byte from receive buffer
- byte_valid  input  1  byte_in valid
- byte_last  input  1  marks final byte of host frame; qualified by byte_valid
- byte_ready  output  1  parser accepts byte this cycle
- locality_in  input  8  one-hot locality of the current frame; sampled with the first byte
- cmd_ack  input  1  consumer has taken the command
- cmd_valid  output  1  parsed command held stable
- cmd_start_n  output  1  active-low one-cycle pulse on the first cycle of cmd_valid
- tpm_cc  output  32  commandCode
- cmd_param  output  34  packed parameters, see Behaviour
- locality  output  8  latched locality
- auth_handle  output  32  first handle (0 if none)
- parse_rc  output  32  0x00000000 success, 0x0000001E BAD_TAG, 0x00000142 COMMAND_SIZE

Behaviour:
- Reset (async, reset_n low), all outputs take these values, and state goes to IDLE:
  - byte_ready = 0; cmd_valid = 0; cmd_start_n = 1.
  - tpm_cc, cmd_param, auth_handle and parse_rc are cleared to 0; locality = 0.
  - Reset in mid-frame abandons the frame with no partial output.
- Transfer: a byte is accepted when byte_valid && byte_ready.
  - byte_ready = 1 in every state except EMIT.
  - All multi-byte fields are big-endian; cnt (SIZE_W) counts accepted bytes of the frame.
- States:
  - IDLE: first byte → TAG (byte 0); locality latched.
  - TAG: after byte 1, tag must be 0x8001 or 0x8002, else rc = BAD_TAG → DRAIN. Otherwise → SIZE.
  - SIZE: 4 bytes. If commandSize < 10 or > MAX_CMD_SIZE, rc = COMMAND_SIZE → DRAIN. Otherwise → CC.
  - CC: 4 bytes into tpm_cc. Handle count is 1 for 0x121 (HierarchyControl), 0 for all other codes. Next state is HANDLE if count is 1, else AUTHSZ if tag is 0x8002, else PARAM.
  - HANDLE: 4 bytes into auth_handle. Then → AUTHSZ if tag is 0x8002, else PARAM.
  - AUTHSZ: 4 bytes. Then → AUTHSKIP (discards authSize bytes); authSize = 0 goes straight to PARAM.
  - PARAM: bytes are captured into cmd_param according to tpm_cc:
    - 0x144 Startup / 0x145 Shutdown: 2 bytes → [15:0].
    - 0x143 SelfTest: 1 byte; [0] = (byte != 0).
    - 0x121 HierarchyControl: 4-byte enable → [32:1], then 1 state byte; [0] = (byte != 0).
    - Any other code: bytes discarded; cmd_param = 0.
    - Bits not written are 0.
  - DRAIN: discards bytes until byte_last, then → EMIT.
  - EMIT: holds outputs with cmd_valid = 1 until cmd_ack, then → IDLE next cycle.
- Frame end:
  - Normal end: the byte with cnt+1 == commandSize must carry byte_last. Then → EMIT with rc = 0 unless already set.
  - Size error: COMMAND_SIZE, then go to DRAIN or EMIT, in either of these cases:
    - byte_last arrives before commandSize bytes are accepted;
    - commandSize is reached without byte_last.
  - Short frame: if commandSize ends before a required handle/authSize/parameter field is complete, rc = COMMAND_SIZE.
- Latency: cmd_valid rises on the cycle after the final byte is accepted. cmd_start_n is low on that same cycle only.
- Error priority: the first error detected wins; later errors do not overwrite parse_rc.
- EMIT backpressure: byte_ready = 0 while cmd_valid, so no byte is lost.
- cmd_ack: asserted in the same cycle as cmd_valid rises is legal. cmd_ack outside EMIT is ignored.

Test Plan:
- Startup(CLEAR) stream 80 01 00 00 00 0C 00 00 01 44 00 00, last on byte 11 → cmd_valid one cycle after byte 11; tpm_cc=0x144, cmd_param=0, parse_rc=0, cmd_start_n low for 1 cycle.
- HierarchyControl with tag 0x8002, size 0x20:
  - Stream: handle 4000000C, authSize 9, 9 auth bytes, enable 4000000B, state 01.
  - Expect auth_handle=0x4000000C, cmd_param={32'h4000000B,1'b1}, rc=0.
- Tag 0x8003, last on byte 11 → parse_rc=0x1E, no field capture beyond the tag, cmd_valid only after byte_last.
- Size mismatches:
  - commandSize 0x0C with byte_last on byte 9 → rc=0x142, cmd_valid next cycle.
  - commandSize 0x06 → rc=0x142, drains to byte_last.
- Backpressure and reset:
  - Hold cmd_ack low 20 cycles while the next frame is offered → byte_ready=0 and outputs stable; ack → next frame parses correctly.
  - reset_n low at byte 5 → all outputs at reset values, next full frame parses correctly.
